// File: rtl/dcj11_pkg.sv
// dcj11_pkg: shared definitions for the DCJ11 DAL/AIO bus initiator.
// Holds the AIO cycle codes, the bank-select codes, the initiator state type,
// and the packing of the high address word onto the DAL.
package dcj11_pkg;

    localparam logic [3:0] NIO           = 4'b1111;
    localparam logic [3:0] GP_READ       = 4'b1110;
    localparam logic [3:0] INTERRUPT_ACK = 4'b1101;
    localparam logic [3:0] REQUEST_READ  = 4'b1100;
    localparam logic [3:0] RMW_NOLOCK    = 4'b1011;
    localparam logic [3:0] RMW_BUSLOCK   = 4'b1010;
    localparam logic [3:0] DATA_READ     = 4'b1001;
    localparam logic [3:0] DEMAND_READ   = 4'b1000;
    localparam logic [3:0] GP_WRITE      = 4'b0101;
    localparam logic [3:0] BYTE_WRITE    = 4'b0011;
    localparam logic [3:0] WORD_WRITE    = 4'b0001;

    localparam logic [1:0] BS_MEM = 2'b00;
    localparam logic [1:0] BS_SYS = 2'b01;
    localparam logic [1:0] BS_EXT = 2'b10;
    localparam logic [1:0] BS_INT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_STB,
        S_REC
    } state_t;

    // High address word: addr[20] on DAL0, bank select on DAL7:6,
    // addr[21] on DAL8, addr[19:16] on DAL12:9, everything else zero.
    function automatic logic [15:0] pack_dal_hi(input logic [21:0] addr, input logic [1:0] bs);
        return {3'b000, addr[19:16], addr[21], bs[1], bs[0], 5'b00000, addr[20]};
    endfunction

endpackage

// File: rtl/dcj11_bus_initiator.sv
// dcj11_bus_initiator: CPU-side bus-cycle initiator for the DCJ11 DAL/AIO bus.
// Ports:
//   clk, rst                        bus clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake (accepted when both high)
//   req_aio, req_bs, req_addr, req_wdata  latched request fields
//   rsp_valid, rsp_rdata, rsp_nxm   one-cycle completion with read data / NXM flag
//   ale_n, sctl_n, bufctl_n, aio    bus control pins
//   dal_o, dal_oe, dal_i            multiplexed DAL drive, enable and sample
//   nxm_n                           non-existent-memory abort input
module dcj11_bus_initiator
    import dcj11_pkg::*;
#(
    parameter int T_LO  = 2,
    parameter int T_HI  = 2,
    parameter int T_STB = 4,
    parameter int T_REC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_aio,
    input  logic [1:0]  req_bs,
    input  logic [21:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_nxm,
    output logic        ale_n,
    output logic        sctl_n,
    output logic        bufctl_n,
    output logic [3:0]  aio,
    output logic [15:0] dal_o,
    output logic        dal_oe,
    input  logic [15:0] dal_i,
    input  logic        nxm_n
);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  aio_q;
    logic [1:0]  bs_q;
    logic [21:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        nxm_q;
    logic        rsp_pend;
    logic        last;
    logic        rd;
    logic        gp;
    logic        accept;

    assign last   = cnt == 4'd1;
    assign rd     = aio_q[3];
    assign gp     = aio_q == GP_READ || aio_q == GP_WRITE;
    assign accept = state == S_IDLE && req_valid;

    assign rsp_valid = rsp_pend;
    assign rsp_rdata = rdata_q;
    assign rsp_nxm   = rsp_pend & nxm_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt - 4'd1;
        req_ready = 1'b0;
        ale_n     = 1'b1;
        sctl_n    = 1'b1;
        bufctl_n  = 1'b1;
        aio       = NIO;
        dal_o     = 16'h0000;
        dal_oe    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                cnt_n     = cnt;
                // NIO skips the bus entirely and responds from a one-cycle REC.
                if (req_valid) begin
                    state_n = req_aio == NIO ? S_REC : S_ADDR_LO;
                    cnt_n   = req_aio == NIO ? 4'd1 : 4'(T_LO);
                end
            end
            S_ADDR_LO: begin
                ale_n  = 1'b0;
                aio    = aio_q;
                dal_oe = 1'b1;
                dal_o  = gp ? {8'h00, addr_q[7:0]} : addr_q[15:0];
                if (last) begin
                    state_n = S_ADDR_HI;
                    cnt_n   = 4'(T_HI);
                end
            end
            S_ADDR_HI: begin
                ale_n  = 1'b0;
                aio    = aio_q;
                dal_oe = 1'b1;
                dal_o  = pack_dal_hi(addr_q, bs_q);
                if (last) begin
                    state_n = S_STB;
                    cnt_n   = 4'(T_STB);
                end
            end
            S_STB: begin
                ale_n    = 1'b0;
                sctl_n   = 1'b0;
                aio      = aio_q;
                dal_oe   = ~rd;
                bufctl_n = ~rd;
                dal_o    = rd ? 16'h0000 : wdata_q;
                if (last) begin
                    state_n = S_REC;
                    cnt_n   = 4'(T_REC);
                end
            end
            S_REC: begin
                if (last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            aio_q    <= NIO;
            bs_q     <= BS_MEM;
            addr_q   <= 22'd0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            nxm_q    <= 1'b0;
            rsp_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rsp_pend <= state_n == S_REC && state != S_REC;
            if (accept) begin
                aio_q   <= req_aio;
                bs_q    <= req_bs;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                nxm_q   <= 1'b0;
                if (req_aio == NIO) rdata_q <= 16'h0000;
            end
            if (state == S_STB) begin
                if (!nxm_n) nxm_q <= 1'b1;
                // The response word is settled on the last strobe edge so it
                // appears together with rsp_valid and then holds.
                if (last) rdata_q <= (rd && nxm_n && !nxm_q) ? dal_i : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_dcj11_bus_initiator.sv
// tb_dcj11_bus_initiator: scoreboard bench for dcj11_bus_initiator.
// Stimulus pushes expected pin snapshots and responses into queues; a monitor
// compares them against the DUT on the falling edge.
module tb_dcj11_bus_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_aio = 4'hF;
    logic [1:0]  req_bs = 2'b00;
    logic [21:0] req_addr = 22'd0;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_nxm;
    logic        ale_n, sctl_n, bufctl_n, dal_oe;
    logic [3:0]  aio;
    logic [15:0] dal_o;
    logic [15:0] dal_i = 16'h0000;
    logic        nxm_n = 1'b1;

    typedef struct {
        int          cyc;
        logic        ale, sctl, bn, oe;
        logic [15:0] dal;
        bit          cd;
        logic [3:0]  code;
        bit          ca;
    } pin_t;

    typedef struct {
        int          cyc;
        logic [15:0] rdata;
        logic        nxm;
    } rsp_t;

    pin_t pq[$];
    rsp_t rq[$];
    pin_t p;
    rsp_t r;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   nxm_at = -1;

    dcj11_bus_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aio(req_aio), .req_bs(req_bs), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nxm(rsp_nxm),
        .ale_n(ale_n), .sctl_n(sctl_n), .bufctl_n(bufctl_n), .aio(aio),
        .dal_o(dal_o), .dal_oe(dal_oe), .dal_i(dal_i), .nxm_n(nxm_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) nxm_n = (cyc != nxm_at);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void pp(input int c, input logic ale, input logic sctl, input logic bn,
                               input logic oe, input logic [15:0] dal, input bit cd,
                               input logic [3:0] code, input bit ca);
        pin_t e;
        e = '{c, ale, sctl, bn, oe, dal, cd, code, ca};
        pq.push_back(e);
    endfunction

    task automatic issue(input logic [3:0] code, input logic [1:0] bs, input logic [21:0] addr,
                         input logic [15:0] wd, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [15:0] drv, input logic [15:0] exp_rd, input logic exp_nxm,
                         input int nxm_off, input bit hold, input bit track, output int a);
        int  g;
        bit  rdc;
        rdc = code[3];
        @(negedge clk);
        req_aio   = code;
        req_bs    = bs;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout at cycle %0d: req_ready got 0 expected 1", cyc);
        end
        a      = cyc;
        dal_i  = drv;
        nxm_at = nxm_off > 0 ? a + nxm_off : -1;
        if (track) begin
            if (code == 4'hF) begin
                pp(a + 1, 1, 1, 1, 0, 16'h0, 0, 4'hF, 1);
                pp(a + 2, 1, 1, 1, 0, 16'h0, 0, 4'hF, 1);
                rq.push_back('{a + 1, 16'h0000, 1'b0});
            end else begin
                for (int k = 1; k <= 2; k++) pp(a + k, 0, 1, 1, 1, lo, 1, code, 1);
                for (int k = 3; k <= 4; k++) pp(a + k, 0, 1, 1, 1, hi, 1, code, 0);
                for (int k = 5; k <= 8; k++) pp(a + k, 0, 0, !rdc, !rdc, wd, !rdc, code, 0);
                pp(a + 9, 1, 1, 1, 0, 16'h0, 0, 4'hF, 1);
                rq.push_back('{a + 9, exp_rd, exp_nxm});
            end
        end
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                p = pq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL pin_snapshot_missed for cycle %0d at cycle %0d", p.cyc, cyc);
            end
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                p = pq.pop_front();
                chk("ale_n", 32'(ale_n), 32'(p.ale));
                chk("sctl_n", 32'(sctl_n), 32'(p.sctl));
                chk("bufctl_n", 32'(bufctl_n), 32'(p.bn));
                chk("dal_oe", 32'(dal_oe), 32'(p.oe));
                if (p.cd) chk("dal_o", 32'(dal_o), 32'(p.dal));
                if (p.ca) chk("aio", 32'(aio), 32'(p.code));
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp_valid at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    chk("rsp_nxm", 32'(rsp_nxm), 32'(r.nxm));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, a1, a2, g;
        repeat (3) @(negedge clk);
        chk("reset_ale_n", 32'(ale_n), 32'd1);
        chk("reset_sctl_n", 32'(sctl_n), 32'd1);
        chk("reset_bufctl_n", 32'(bufctl_n), 32'd1);
        chk("reset_aio", 32'(aio), 32'hF);
        chk("reset_dal_oe", 32'(dal_oe), 32'd0);
        chk("reset_dal_o", 32'(dal_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_rsp_nxm", 32'(rsp_nxm), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // word write to 17777566, bank ext
        issue(4'b0001, 2'b10, 22'o17777566, 16'h0041, 16'hFF76, 16'h1F81,
              16'h0000, 16'h0000, 1'b0, 0, 0, 1, a);
        // data read, responder returns 1234
        issue(4'b1001, 2'b00, 22'o001000, 16'h0000, 16'h0200, 16'h0000,
              16'h1234, 16'h1234, 1'b0, 0, 0, 1, a);
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        chk("read_ready_latency", 32'(cyc - a), 32'd11);
        // NXM in the second strobe cycle only
        issue(4'b1001, 2'b10, 22'o17777000, 16'h0000, 16'hFE00, 16'h1F81,
              16'hBEEF, 16'h0000, 1'b1, 6, 0, 1, a);
        // next clean read clears the flag
        issue(4'b1001, 2'b00, 22'o001000, 16'h0000, 16'h0200, 16'h0000,
              16'h5555, 16'h5555, 1'b0, 0, 0, 1, a);
        // GP read: upper address byte must not reach the DAL
        issue(4'b1110, 2'b00, 22'o177400, 16'h0000, 16'h0000, 16'h0000,
              16'h0003, 16'h0003, 1'b0, 0, 0, 1, a);

        // reset in the middle of a write strobe
        issue(4'b0001, 2'b00, 22'o000100, 16'h9999, 16'h0, 16'h0,
              16'h0000, 16'h0000, 1'b0, 0, 0, 0, a);
        while (cyc < a + 6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ale_n", 32'(ale_n), 32'd1);
        chk("midrst_sctl_n", 32'(sctl_n), 32'd1);
        chk("midrst_dal_oe", 32'(dal_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (12) @(negedge clk);

        // back-to-back with req_valid held, then NIO
        issue(4'b0011, 2'b01, 22'o000002, 16'h00AA, 16'h0002, 16'h0040,
              16'h0000, 16'h0000, 1'b0, 0, 1, 1, a1);
        issue(4'b1001, 2'b11, 22'o000004, 16'h0000, 16'h0004, 16'h00C0,
              16'hCAFE, 16'hCAFE, 1'b0, 0, 0, 1, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd11);
        issue(4'b1111, 2'b00, 22'o000000, 16'h0000, 16'h0, 16'h0,
              16'h0000, 16'h0000, 1'b0, 0, 0, 1, a);

        g = 0;
        while ((pq.size() > 0 || rq.size() > 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (pq.size() > 0 || rq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d pin and %0d response expectations left, expected 0",
                     pq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
